// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, requests words from imem, registers
// them with their PC and presents the opcode field to the control decoder.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_req/addr/ready/rdata     instruction memory request/response
//   stall                         downstream cannot take the IF register
//   redirect_valid/redirect_pc    branch/jump redirect
//   if_valid/instr/pc/pc4/op      IF register outputs
//   fault/fault_cause/fault_pc    fetch fault status
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [5:0]  if_op,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_ALIGN = 2'b01;
  localparam logic [1:0] C_TOUT  = 2'b10;

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int TM1   = TO_EN ? TIMEOUT - 1 : 0;
  localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] cnt;
  logic          xfer;
  logic          consume;
  logic          rd_align;
  logic          to_hit;

  assign imem_req = rst_n && (state == S_FETCH)
                    && (!if_valid || !stall);
  assign imem_addr = pc;
  assign xfer      = imem_req && imem_ready;
  assign consume   = if_valid && !stall;
  assign rd_align  = (redirect_pc[1:0] == 2'b00);
  assign to_hit    = TO_EN && (cnt == CW'(TM1));

  assign if_pc4 = if_pc + 32'd4;
  assign if_op  = if_instr[31:26];
  assign fault  = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= PC_RESET;
      cnt         <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fault_cause <= C_NONE;
      fault_pc    <= '0;
    end else if (state == S_FETCH) begin
      if (redirect_valid) begin
        // Any same-cycle imem response belongs to the old path.
        if_valid <= 1'b0;
        cnt      <= '0;
        if (rd_align) begin
          pc <= redirect_pc;
        end else begin
          state       <= S_FAULT;
          fault_cause <= C_ALIGN;
          fault_pc    <= redirect_pc;
        end
      end else if (xfer) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        pc       <= pc + 32'd4;
        cnt      <= '0;
      end else begin
        if (consume)
          if_valid <= 1'b0;
        if (imem_req) begin
          if (to_hit) begin
            state       <= S_FAULT;
            fault_cause <= C_TOUT;
            fault_pc    <= pc;
            if_valid    <= 1'b0;
            cnt         <= '0;
          end else if (TO_EN) begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end else begin
      if (redirect_valid) begin
        if (rd_align) begin
          state       <= S_FETCH;
          pc          <= redirect_pc;
          fault_cause <= C_NONE;
          if_valid    <= 1'b0;
          cnt         <= '0;
        end else begin
          fault_pc <= redirect_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances, one with TIMEOUT=4 at
// PC 0 and one with TIMEOUT=0 at PC 0xFFFF_FFFC (wrap, no-timeout).
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 0;
  logic        rst_n;
  logic        ready;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic [31:0] a_rdata, b_rdata;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [31:0] a_pc, b_pc;
  logic [31:0] a_pc4, b_pc4;
  logic [5:0]  a_op, b_op;
  logic        a_fault, b_fault;
  logic [1:0]  a_cause, b_cause;
  logic [31:0] a_fpc, b_fpc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign a_rdata = a_addr ^ K;
  assign b_rdata = b_addr ^ K;

  instr_fetch #(.PC_RESET(32'h0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_ready(ready), .imem_rdata(a_rdata),
    .stall(stall),
    .redirect_valid(rv), .redirect_pc(rpc),
    .if_valid(a_valid), .if_instr(a_instr),
    .if_pc(a_pc), .if_pc4(a_pc4), .if_op(a_op),
    .fault(a_fault), .fault_cause(a_cause),
    .fault_pc(a_fpc)
  );

  instr_fetch #(.PC_RESET(32'hFFFF_FFFC), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(ready), .imem_rdata(b_rdata),
    .stall(stall),
    .redirect_valid(rv), .redirect_pc(rpc),
    .if_valid(b_valid), .if_instr(b_instr),
    .if_pc(b_pc), .if_pc4(b_pc4), .if_op(b_op),
    .fault(b_fault), .fault_cause(b_cause),
    .fault_pc(b_fpc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; ready = 1; stall = 0; rv = 0; rpc = 0;
    tick();
    chk("rst_req",   32'(a_req), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_fault", 32'(a_fault), 0);
    chk("rst_cause", 32'(a_cause), 0);
    chk("rst_addr",  a_addr, 0);
    chk("rst_baddr", b_addr, 32'hFFFF_FFFC);

    // 1: streaming fetch
    rst_n = 1; #1;
    chk("t1_req",  32'(a_req), 1);
    chk("t1_addr0", a_addr, 0);
    tick();
    chk("t1_valid", 32'(a_valid), 1);
    chk("t1_pc",    a_pc, 0);
    chk("t1_instr", a_instr, 32'hA5A5_0000);
    chk("t1_op",    32'(a_op), 32'h29);
    chk("t1_pc4",   a_pc4, 4);
    chk("t1_addr1", a_addr, 4);
    chk("t6_bpc",   b_pc, 32'hFFFF_FFFC);
    chk("t6_bpc4",  b_pc4, 0);
    chk("t6_baddr", b_addr, 0);
    tick();
    chk("t1_addr2", a_addr, 8);
    chk("t1_pc2",   a_pc, 4);
    chk("t1_ins2",  a_instr, 32'hA5A5_0004);

    // 2: stall holds everything
    stall = 1; #1;
    chk("t2_req", 32'(a_req), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hreq",  32'(a_req), 0);
      chk("t2_hpc",   a_pc, 4);
      chk("t2_hins",  a_instr, 32'hA5A5_0004);
      chk("t2_haddr", a_addr, 8);
    end
    stall = 0; #1;
    chk("t2_rreq",  32'(a_req), 1);
    chk("t2_raddr", a_addr, 8);
    tick();
    chk("t2_npc",  a_pc, 8);
    chk("t2_nins", a_instr, 32'hA5A5_0008);

    // 3: redirect drops same-cycle response
    rv = 1; rpc = 32'h100;
    tick();
    rv = 0; #1;
    chk("t3_valid", 32'(a_valid), 0);
    chk("t3_addr",  a_addr, 32'h100);
    tick();
    chk("t3_v2",  32'(a_valid), 1);
    chk("t3_pc",  a_pc, 32'h100);
    chk("t3_ins", a_instr, 32'hA5A5_0100);

    // 4: misaligned redirect then recovery
    rv = 1; rpc = 32'h102;
    tick();
    rv = 0; #1;
    chk("t4_fault", 32'(a_fault), 1);
    chk("t4_cause", 32'(a_cause), 1);
    chk("t4_fpc",   a_fpc, 32'h102);
    chk("t4_req",   32'(a_req), 0);
    chk("t4_valid", 32'(a_valid), 0);
    tick();
    chk("t4_hold", 32'(a_fault), 1);
    chk("t4_hreq", 32'(a_req), 0);
    rv = 1; rpc = 32'h80;
    tick();
    rv = 0; #1;
    chk("t4_clr",   32'(a_fault), 0);
    chk("t4_ccau",  32'(a_cause), 0);
    chk("t4_addr",  a_addr, 32'h80);
    chk("t4_rreq",  32'(a_req), 1);
    tick();
    chk("t4_rpc", a_pc, 32'h80);

    // 5: timeout at pc 0x40
    ready = 0; rv = 1; rpc = 32'h40;
    tick();
    rv = 0; #1;
    chk("t5_addr", a_addr, 32'h40);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_pre", 32'(a_fault), 0);
    tick();
    chk("t5_fault", 32'(a_fault), 1);
    chk("t5_cause", 32'(a_cause), 2);
    chk("t5_fpc",   a_fpc, 32'h40);
    chk("t5_req",   32'(a_req), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("t5_bnof", 32'(b_fault), 0);
    chk("t5_breq", 32'(b_req), 1);

    // 6: reset mid-stall
    ready = 1; rv = 1; rpc = 32'h200;
    tick();
    rv = 0;
    tick();
    chk("t6_valid", 32'(a_valid), 1);
    stall = 1;
    tick();
    rst_n = 0;
    tick();
    chk("t6_rvalid", 32'(a_valid), 0);
    chk("t6_rins",   a_instr, 0);
    chk("t6_rpc",    a_pc, 0);
    chk("t6_rfpc",   a_fpc, 0);
    chk("t6_rfault", 32'(a_fault), 0);
    chk("t6_raddr",  a_addr, 0);
    chk("t6_rreq",   32'(a_req), 0);
    chk("t6_rbaddr", b_addr, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
